// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM state encoding and the
// per-transaction mode latched at accept.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL,
    GAP
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Phase divider for the SPI master: emits a one-clock tick every CLK_DIV
// system clocks while enabled; the count is held at zero when disabled.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic preset,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  // Preset skips one count so the following phase is a clock shorter.
  localparam logic [CW-1:0] PRE  = (CLK_DIV > 1) ? CW'(1) : '0;

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable) begin
      count <= '0;
    end else if (preset) begin
      count <= PRE;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master, all four CPOL/CPHA modes, MSB- or LSB-first per
// transaction. One slave, host side is new_data/din/busy/done/dout.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned CLK_DIV = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              new_data,
  input  logic [DATA_W-1:0] din,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              MISO,
  output logic              sync_clock,
  output logic              CS,
  output logic              MOSI,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done
);

  localparam int unsigned EDGES = 2 * DATA_W;
  localparam int unsigned EW    = $clog2(EDGES + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(EDGES - 1);

  spi_state_t        state;
  spi_mode_t         mode;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] tx_next;
  logic [DATA_W-1:0] rx_next;
  logic [EW-1:0]     edge_cnt;
  logic              tick;
  logic              xfer_tick;
  logic              leading;
  logic              last_edge;
  logic              sample_rx;
  logic              shift_tx;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clock (clock),
    .reset (reset),
    .enable(state != IDLE),
    .preset(state == TRAIL && tick),
    .tick  (tick)
  );

  always_comb begin
    xfer_tick = (state == XFER) && tick;
    leading   = ~edge_cnt[0];
    last_edge = (edge_cnt == LAST_EDGE);
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
    sample_rx = xfer_tick && (leading ^ mode.cpha);
    shift_tx  = xfer_tick && (mode.cpha ? (leading && (edge_cnt != '0))
                                        : (!leading && !last_edge));
    tx_next   = mode.lsb_first ? {1'b0, tx_sr[DATA_W-1:1]} : {tx_sr[DATA_W-2:0], 1'b0};
    rx_next   = mode.lsb_first ? {MISO, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], MISO};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mode       <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      edge_cnt   <= '0;
      CS         <= 1'b1;
      sync_clock <= 1'b0;
      MOSI       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dout       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (new_data) begin
            mode       <= {cpol, cpha, lsb_first};
            tx_sr      <= din;
            rx_sr      <= '0;
            edge_cnt   <= '0;
            CS         <= 1'b0;
            sync_clock <= cpol;
            MOSI       <= first_bit(din, lsb_first);
            busy       <= 1'b1;
            state      <= LEAD;
          end
        end
        LEAD: begin
          if (tick) state <= XFER;
        end
        XFER: begin
          if (tick) begin
            sync_clock <= ~sync_clock;
            edge_cnt   <= edge_cnt + EW'(1);
            if (sample_rx) rx_sr <= rx_next;
            if (shift_tx) begin
              tx_sr <= tx_next;
              MOSI  <= first_bit(tx_next, mode.lsb_first);
            end
            if (last_edge) begin
              edge_cnt <= '0;
              state    <= TRAIL;
            end
          end
        end
        TRAIL: begin
          if (tick) begin
            CS    <= 1'b1;
            MOSI  <= 1'b0;
            done  <= 1'b1;
            dout  <= rx_sr;
            state <= GAP;
          end
        end
        GAP: begin
          // GAP is entered with a preset divider, so the CS-high window
          // including the idle accept cycle spans CLK_DIV clocks.
          if (tick) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param (DATA_W=8, CLK_DIV=2) with a mode-aware
// SPI slave model and per-cycle protocol checks.
module tb_spi_master_param;

  localparam int DW = 8;
  localparam int CD = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          new_data;
  logic [DW-1:0] din;
  logic          cpol;
  logic          cpha;
  logic          lsb_first;
  logic          MISO;
  logic          sync_clock;
  logic          CS;
  logic          MOSI;
  logic [DW-1:0] dout;
  logic          busy;
  logic          done;

  always #5 clock = ~clock;

  spi_master_param #(
    .DATA_W (DW),
    .CLK_DIV(CD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .new_data  (new_data),
    .din       (din),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .MISO      (MISO),
    .sync_clock(sync_clock),
    .CS        (CS),
    .MOSI      (MOSI),
    .dout      (dout),
    .busy      (busy),
    .done      (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model: presents s_word in the bench's bit order, advancing per CPHA.
  bit          t_cpha = 1'b0;
  bit          t_lsb  = 1'b0;
  logic [7:0]  s_word = '0;
  logic [2:0]  sidx   = '0;
  assign MISO = t_lsb ? s_word[sidx] : s_word[3'd7 - sidx];

  logic       prev_cs   = 1'b1;
  logic       prev_sclk = 1'b0;
  logic       prev_mosi = 1'b0;
  logic       prev_done = 1'b0;
  int         tog = 0, cslow = 0, cshigh = 0, last_gap = 0;
  int         win_tog = 0, win_cslow = 0;
  logic [7:0] mseq = '0, win_mosi = '0;

  always @(negedge clock) begin
    if (!CS) begin
      check("cs_low_implies_busy", busy, 1'b1);
      if (prev_cs) begin
        tog = 0; cslow = 0; mseq = '0; last_gap = cshigh;
      end
      cslow++;
      if (!prev_cs && sync_clock !== prev_sclk) begin
        tog++;
        if (((tog % 2) == 1) != t_cpha) mseq = {mseq[6:0], prev_mosi};
        if (!t_cpha && (tog % 2) == 0 && sidx != 3'd7) sidx++;
        if (t_cpha && (tog % 2) == 1 && tog > 1 && sidx != 3'd7) sidx++;
      end
    end else begin
      if (prev_cs) check("sclk_stable_cs_high", sync_clock, prev_sclk);
      if (!prev_cs) begin
        if (!reset) check("toggles_per_window", tog, 2 * DW);
        win_tog = tog; win_cslow = cslow; win_mosi = mseq; cshigh = 0;
      end
      cshigh++;
      sidx = '0;
    end
    if (prev_done) check("done_one_clock", done, 1'b0);
    prev_cs = CS; prev_sclk = sync_clock; prev_mosi = MOSI; prev_done = done;
  end

  typedef struct {
    logic       cpol, cpha, lsb;
    logic [7:0] din, sw, exp_dout, exp_mosi;
    logic       exp_first;
  } vec_t;

  vec_t vecs[5];

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_idle_wait"}, busy, 1'b0);
  endtask

  task automatic wait_done(input string tag, inout int n);
    while (n < 200 && !done) begin
      @(negedge clock); #1;
      n++;
    end
    check({tag, "_done_latency"}, n, 1 + CD * (2 * DW + 2));
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int n = 0;
    wait_idle(tag);
    @(negedge clock); #1;
    t_cpha = v.cpha; t_lsb = v.lsb; s_word = v.sw;
    cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb; din = v.din; new_data = 1'b1;
    @(posedge clock); #1;
    new_data = 1'b0;
    din = ~v.din; cpol = ~v.cpol; cpha = ~v.cpha; lsb_first = ~v.lsb;
    @(negedge clock); #1;
    n = 1;
    check({tag, "_lead_cs"}, CS, 1'b0);
    check({tag, "_lead_sclk"}, sync_clock, v.cpol);
    check({tag, "_lead_mosi"}, MOSI, v.exp_first);
    check({tag, "_lead_busy"}, busy, 1'b1);
    wait_done(tag, n);
    check({tag, "_dout"}, dout, v.exp_dout);
    check({tag, "_mosi_seq"}, win_mosi, v.exp_mosi);
    check({tag, "_cs_low_clocks"}, win_cslow, CD * (2 * DW + 2));
    check({tag, "_edges"}, win_tog, 2 * DW);
    check({tag, "_idle_sclk"}, sync_clock, v.cpol);
    check({tag, "_cs_after"}, CS, 1'b1);
    check({tag, "_mosi_after"}, MOSI, 1'b0);
  endtask

  initial begin
    int n;
    bit seen;

    vecs[0] = '{cpol:0, cpha:0, lsb:0, din:8'hA5, sw:8'h3C, exp_dout:8'h3C, exp_mosi:8'hA5, exp_first:1};
    vecs[1] = '{cpol:1, cpha:1, lsb:1, din:8'h81, sw:8'h81, exp_dout:8'h81, exp_mosi:8'h81, exp_first:1};
    vecs[2] = '{cpol:0, cpha:1, lsb:0, din:8'hFF, sw:8'h5A, exp_dout:8'h5A, exp_mosi:8'hFF, exp_first:1};
    vecs[3] = '{cpol:1, cpha:0, lsb:0, din:8'h00, sw:8'h5A, exp_dout:8'h5A, exp_mosi:8'h00, exp_first:0};
    vecs[4] = '{cpol:0, cpha:0, lsb:1, din:8'h0F, sw:8'hC3, exp_dout:8'hC3, exp_mosi:8'hF0, exp_first:1};

    reset = 1'b1; new_data = 1'b0; din = '0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_cs", CS, 1'b1);
    check("rst_sclk", sync_clock, 1'b0);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dout", dout, 8'h00);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Back-to-back with new_data held high; din change during busy ignored.
    wait_idle("b2b");
    @(negedge clock); #1;
    t_cpha = 0; t_lsb = 0; s_word = 8'h69;
    cpol = 0; cpha = 0; lsb_first = 0; din = 8'h96; new_data = 1'b1;
    @(posedge clock); #1;
    din = 8'h33;
    n = 0;
    wait_done("b2b_1", n);
    check("b2b_1_dout", dout, 8'h69);
    check("b2b_1_mosi_seq", win_mosi, 8'h96);
    s_word = 8'hC5;
    n = 0;
    while (CS && n < 20) begin
      @(negedge clock); #1;
      n++;
    end
    check("b2b_refire_delay", n, 2);
    check("b2b_cs_high_gap", last_gap, CD);
    new_data = 1'b0;
    n = 1;
    wait_done("b2b_2", n);
    check("b2b_2_dout", dout, 8'hC5);
    check("b2b_2_mosi_seq", win_mosi, 8'h33);

    // Reset at sync_clock edge 7 aborts the transaction immediately.
    wait_idle("abort");
    @(negedge clock); #1;
    t_cpha = 0; t_lsb = 0; s_word = 8'h3C;
    cpol = 0; cpha = 0; lsb_first = 0; din = 8'hA5; new_data = 1'b1;
    @(posedge clock); #1;
    new_data = 1'b0;
    n = 0;
    while (tog != 7 && n < 100) begin
      @(negedge clock); #1;
      n++;
    end
    check("abort_edge7_reached", tog, 7);
    reset = 1'b1;
    #1;
    check("abort_cs", CS, 1'b1);
    check("abort_sclk", sync_clock, 1'b0);
    check("abort_mosi", MOSI, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_dout", dout, 8'h00);
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);
    check("abort_dout_kept", dout, 8'h00);
    run_txn(vecs[0], "post_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
